// File: rtl/n4by2_b2_idiv_loader_pkg.sv
// Shared definitions for the serial loader around the 4/2 signed divider.
// Holds the FSM state encoding and the fixed operand widths used by the
// loader top and its serial shift registers.
package n4by2_b2_idiv_loader_pkg;

  // Widths of the combinational divider this stage feeds.
  localparam int NX    = 4;
  localparam int NY    = 2;

  // Bit counter must reach NX-1 (the widest operand).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    EVAL   = 2'b10,
    HOLD   = 2'b11
  } state_e;

endpackage

// File: rtl/n4by2_b2_idiv_loader_serial_shifter.sv
// n_b2_serial_shifter: MSB-first serial-in, parallel-out shift register.
// Ports:
//   clock    - rising-edge clock
//   reset_   - asynchronous active-low reset, clears the register
//   shift_en - when high, shift din in at the LSB on the next edge
//   din      - serial input bit
//   data     - parallel register contents (first bit ends up at the MSB)
module n_b2_serial_shifter
  import n4by2_b2_idiv_loader_pkg::*;
#(
  parameter int W = NX
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] data
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (shift_en) begin
      data_d = {data_q[W-2:0], din};
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/n4by2_b2_idiv_loader.sv
// n4by2_b2_idiv_loader: serial front end and registered back end for the
// combinational 4/2 signed divider.
// Ports:
//   clock, reset_           - clock (rising edge), async active-low reset
//   din, din_valid/ready    - serial operand bits, MSB first: x3..x0, y1..y0
//   x3_x0, y1_y0            - registered operands driven to the divider
//   dq1_dq0, dr1_dr0,
//   d_no_idiv               - divider quotient, remainder, infeasibility
//   res_valid/res_ready     - result handshake
//   q1_q0, r1_r0, no_idiv   - registered divider outputs
//   err_count               - saturating count of infeasible results
module n4by2_b2_idiv_loader #(
  parameter int NX = 4,
  parameter int NY = 2,
  parameter int NC = 4
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [NX-1:0] x3_x0,
  output logic [NY-1:0] y1_y0,
  input  logic [NY-1:0] dq1_dq0,
  input  logic [NY-1:0] dr1_dr0,
  input  logic          d_no_idiv,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [NY-1:0] q1_q0,
  output logic [NY-1:0] r1_r0,
  output logic          no_idiv,
  output logic [NC-1:0] err_count
);

  import n4by2_b2_idiv_loader_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NY-1:0]      q_q, q_d;
  logic [NY-1:0]      r_q, r_d;
  logic               no_idiv_q, no_idiv_d;
  logic [NC-1:0]      err_q, err_d;
  logic               shift_x;
  logic               shift_y;

  n_b2_serial_shifter #(.W(NX)) u_x_shift (
    .clock    (clock),
    .reset_   (reset_),
    .shift_en (shift_x),
    .din      (din),
    .data     (x3_x0)
  );

  n_b2_serial_shifter #(.W(NY)) u_y_shift (
    .clock    (clock),
    .reset_   (reset_),
    .shift_en (shift_y),
    .din      (din),
    .data     (y1_y0)
  );

  // Next-state and Moore outputs. A bit moves only while the FSM sits in a
  // LOAD state, so din_valid in EVAL/HOLD has no effect; the counter wraps
  // to zero when an operand is complete.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    no_idiv_d = no_idiv_q;
    err_d     = err_q;
    shift_x   = 1'b0;
    shift_y   = 1'b0;
    din_ready = 1'b0;
    res_valid = 1'b0;

    unique case (state_q)
      LOAD_X: begin
        din_ready = 1'b1;
        if (din_valid) begin
          shift_x = 1'b1;
          if (cnt_q == CNT_W'(NX - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_Y;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_Y: begin
        din_ready = 1'b1;
        if (din_valid) begin
          shift_y = 1'b1;
          if (cnt_q == CNT_W'(NY - 1)) begin
            cnt_d   = '0;
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        // Divider has had a full cycle to settle on the new operands.
        q_d       = dq1_dq0;
        r_d       = dr1_dr0;
        no_idiv_d = d_no_idiv;
        if (d_no_idiv && (err_q != {NC{1'b1}})) begin
          err_d = err_q + 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = LOAD_X;
        end
      end
      default: state_d = LOAD_X;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= LOAD_X;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      no_idiv_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      no_idiv_q <= no_idiv_d;
      err_q     <= err_d;
    end
  end

  assign q1_q0     = q_q;
  assign r1_r0     = r_q;
  assign no_idiv   = no_idiv_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_n4by2_b2_idiv_loader.sv
// Self-checking bench for n4by2_b2_idiv_loader. Provides a behavioural
// 4/2 signed divider and an arithmetic reference model of the loader.
module tb_n4by2_b2_idiv_loader;

  logic       clock = 1'b0;
  logic       reset_;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] x3_x0;
  logic [1:0] y1_y0;
  logic [1:0] dq1_dq0;
  logic [1:0] dr1_dr0;
  logic       d_no_idiv;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] q1_q0;
  logic [1:0] r1_r0;
  logic       no_idiv;
  logic [3:0] err_count;

  int testCount = 0;
  int failCount = 0;

  // Reference model state: operand values, last captured result, error count.
  int mx, my, mq, mr, mni, merr;

  n4by2_b2_idiv_loader #(.NX(4), .NY(2), .NC(4)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x3_x0     (x3_x0),
    .y1_y0     (y1_y0),
    .dq1_dq0   (dq1_dq0),
    .dr1_dr0   (dr1_dr0),
    .d_no_idiv (d_no_idiv),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .q1_q0     (q1_q0),
    .r1_r0     (r1_r0),
    .no_idiv   (no_idiv),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Signed division, truncating toward zero; infeasible when divisor is 0
  // or the quotient does not fit in 2 signed bits (outputs forced to 0).
  function automatic void divRef(input int xv, input int yv,
                                 output int q, output int r, output int ni);
    int xs, ys, qi, ri;
    xs = (xv >= 8) ? xv - 16 : xv;
    ys = (yv >= 2) ? yv - 4 : yv;
    q = 0; r = 0; ni = 1;
    if (ys != 0) begin
      qi = xs / ys;
      ri = xs % ys;
      if (qi >= -2 && qi <= 1) begin
        q  = qi & 3;
        r  = ri & 3;
        ni = 0;
      end
    end
  endfunction

  // External divider model.
  always_comb begin
    int q, r, ni;
    divRef(int'(x3_x0), int'(y1_y0), q, r, ni);
    dq1_dq0   = q[1:0];
    dr1_dr0   = r[1:0];
    d_no_idiv = ni[0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_x"}, 32'(x3_x0), 32'(mx));
    checkOutput({tag, "_y"}, 32'(y1_y0), 32'(my));
    checkOutput({tag, "_q"}, 32'(q1_q0), 32'(mq));
    checkOutput({tag, "_r"}, 32'(r1_r0), 32'(mr));
    checkOutput({tag, "_ni"}, 32'(no_idiv), 32'(mni));
    checkOutput({tag, "_err"}, 32'(err_count), 32'(merr));
  endtask

  // Send one serial bit after 'gap' idle cycles; the model folds it into
  // the operand currently being loaded.
  task automatic applyStimulus(input logic b, input int gap, input bit toY);
    repeat (gap) begin
      din_valid = 1'b0;
      din       = 1'($urandom);
      @(posedge clock); #1;
      checkOutput("stall_x", 32'(x3_x0), 32'(mx));
      checkOutput("stall_y", 32'(y1_y0), 32'(my));
    end
    checkOutput("din_ready", 32'(din_ready), 32'd1);
    din       = b;
    din_valid = 1'b1;
    @(posedge clock); #1;
    din_valid = 1'b0;
    if (toY) my = (my * 2 + int'(b)) % 4;
    else     mx = (mx * 2 + int'(b)) % 16;
    checkOutput(toY ? "shift_y" : "shift_x", toY ? 32'(y1_y0) : 32'(x3_x0),
                toY ? 32'(my) : 32'(mx));
  endtask

  task automatic loadOp(input logic [3:0] x, input logic [1:0] y, input int maxGap);
    for (int i = 3; i >= 0; i--) applyStimulus(x[i], $urandom_range(0, maxGap), 1'b0);
    for (int i = 1; i >= 0; i--) applyStimulus(y[i], $urandom_range(0, maxGap), 1'b1);
    checkOutput("eval_res_valid", 32'(res_valid), 32'd0);
    checkOutput("eval_din_ready", 32'(din_ready), 32'd0);
    divRef(mx, my, mq, mr, mni);
    if (mni == 1 && merr < 15) merr++;
    @(posedge clock); #1;
    checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
    checkRegs("result");
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    checkOutput("after_take_din_ready", 32'(din_ready), 32'd1);
    checkOutput("after_take_res_valid", 32'(res_valid), 32'd0);
    checkRegs("after_take");
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic asyncReset(input string tag);
    #2 reset_ = 1'b0;
    #1;
    mx = 0; my = 0; mq = 0; mr = 0; mni = 0; merr = 0;
    checkRegs(tag);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    checkOutput({tag, "_din_ready"}, 32'(din_ready), 32'd1);
  endtask

  initial begin
    reset_ = 1'b0; din = 1'b0; din_valid = 1'b0; res_ready = 1'b0;
    mx = 0; my = 0; mq = 0; mr = 0; mni = 0; merr = 0;
    #12;
    checkRegs("reset");
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    checkOutput("reset_din_ready", 32'(din_ready), 32'd1);

    // 3 / -2 without stalls: q=-1, r=1.
    loadOp(4'b0011, 2'b10, 0);
    checkOutput("t1_q", 32'(q1_q0), 32'b11);
    checkOutput("t1_r", 32'(r1_r0), 32'b01);
    consume();

    // -1 / 1 with gaps between bits.
    loadOp(4'b1111, 2'b01, 3);
    checkOutput("t2_q", 32'(q1_q0), 32'b11);
    consume();

    // Quotient overflow, then divide by zero.
    loadOp(4'b0110, 2'b01, 0);
    checkOutput("t3_err1", 32'(err_count), 32'd1);
    consume();
    loadOp(4'b0001, 2'b00, 1);
    checkOutput("t3_err2", 32'(err_count), 32'd2);

    // Stall in HOLD while din_valid is asserted.
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1;
      din       = 1'($urandom);
      @(posedge clock); #1;
      checkOutput("hold_din_ready", 32'(din_ready), 32'd0);
      checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
      checkRegs("hold");
    end
    din_valid = 1'b0;
    consume();

    // Reset mid-load, then reset during HOLD.
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    asyncReset("rst_load");
    loadOp(4'b0111, 2'b11, 1);
    asyncReset("rst_hold");
    loadOp(4'b0001, 2'b01, 0);
    checkOutput("t5_q", 32'(q1_q0), 32'b01);
    checkOutput("t5_r", 32'(r1_r0), 32'b00);
    consume();

    // err_count saturation.
    for (int i = 0; i < 17; i++) begin
      loadOp(4'($urandom), 2'b00, 0);
      consume();
    end
    checkOutput("sat_err", 32'(err_count), 32'd15);

    // Randomized operations with random gaps and HOLD waits.
    asyncReset("rst_rand");
    for (int i = 0; i < 30; i++) begin
      loadOp(4'($urandom), 2'($urandom), 2);
      repeat ($urandom_range(0, 3)) begin
        din_valid = 1'($urandom);
        @(posedge clock); #1;
        checkOutput("rand_hold_valid", 32'(res_valid), 32'd1);
        checkRegs("rand_hold");
      end
      din_valid = 1'b0;
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/n4by2_b2_idiv_loader.md
Name: n4by2_b2_idiv_loader

Overview:
- Sequential front/back stage for the combinational 4/2 signed two's-complement integer divider.
- Collects dividend and divisor serially, one bit per handshake, MSB first.
- Drives the divider's operand inputs and samples its quotient, remainder and no_idiv flag.
- Holds the result behind a valid/ready handshake.
- Keeps a saturating count of infeasible divisions.

Parameters:
NX, 4, dividend width in bits (the divider is fixed at 4; other values are unsupported)
NY, 2, divisor/quotient/remainder width in bits (fixed at 2)
NC, 4, width of err_count

Ports:
clock  in  1  system clock, rising edge
reset_  in  1  asynchronous active-low reset
din  in  1  serial operand bit, MSB first: x3..x0, then y1..y0
din_valid  in  1  din carries a bit
din_ready  out  1  stage accepts a bit this cycle
x3_x0  out  NX  dividend to divider (registered)
y1_y0  out  NY  divisor to divider (registered)
dq1_dq0  in  NY  quotient from divider
dr1_dr0  in  NY  remainder from divider
d_no_idiv  in  1  infeasibility flag from divider
res_valid  out  1  result registers valid
res_ready  in  1  consumer takes result
q1_q0  out  NY  registered quotient
r1_r0  out  NY  registered remainder
no_idiv  out  1  registered infeasibility flag
err_count  out  NC  saturating count of results with no_idiv=1

Behaviour:
- Reset (reset_=0, asynchronous, any state):
  - state=LOAD_X, bit counter=0.
  - x3_x0, y1_y0, q1_q0, r1_r0, no_idiv, err_count all 0.
  - res_valid=0, din_ready=1 (after reset is released).
  - Reset mid-load or mid-hold discards the partial operand or unconsumed result.
- A bit is transferred on a rising edge with din_valid & din_ready.
- din_ready=1 only in LOAD_X and LOAD_Y. res_valid=1 only in HOLD.
- FSM (Moore outputs):
  - LOAD_X: on transfer, x3_x0 <= {x3_x0[NX-2:0], din}, cnt++. When the NX-th bit is transferred: cnt<=0, go to LOAD_Y.
  - LOAD_Y: on transfer, y1_y0 <= {y1_y0[NY-2:0], din}, cnt++. When the NY-th bit is transferred: cnt<=0, go to EVAL.
  - EVAL: exactly one cycle; the divider settles.
    - At the closing edge: q1_q0<=dq1_dq0, r1_r0<=dr1_dr0, no_idiv<=d_no_idiv.
    - If d_no_idiv=1 and err_count is below its maximum, err_count++.
    - Go to HOLD.
  - HOLD: res_valid=1; outputs stable. On an edge with res_ready=1, go to LOAD_X. Otherwise stay in HOLD indefinitely.
- Latency: last divisor bit accepted at edge E; res_valid=1 from edge E+1. Minimum 6 transfers + 1 EVAL + 1 HOLD cycle per operation = 8 cycles.
- Bit stalls: din_valid=0 in a LOAD state holds the counter and shift registers unchanged.
- Ignored inputs: din_valid while din_ready=0 is ignored, with no side effect.
- res_ready outside HOLD is ignored.
- Operand registers are not cleared between operations; they are fully overwritten during the next load.
- After leaving HOLD, q1_q0/r1_r0/no_idiv keep their values but are not valid.
- err_count saturates at 2^NC-1 and is cleared only by reset.
- Divider function (external, combinational), signed two's complement:
  - Quotient truncates toward 0.
  - Remainder takes the dividend's sign.
  - d_no_idiv=1 when the divisor is 0 or the quotient overflows 2 bits.

Decomposition:
- Shared package holds:
  - State encoding LOAD_X=2'b00, LOAD_Y=2'b01, EVAL=2'b10, HOLD=2'b11.
  - Width constants NX=4, NY=2.
- One natural sub-module: n_b2_serial_shifter, an MSB-first shift register with load-enable, instantiated twice (dividend, divisor).
- The divider is instantiated outside this block, in the enclosing top.

Test Plan (bench connects the existing 4/2 signed divider):
1. Shift in 0011 then 10 (3 / -2), no stalls.
   - Response: res_valid rises 1 cycle after the last bit; q1_q0=11, r1_r0=01, no_idiv=0, err_count=0.
2. Shift in 1111 then 01 (-1 / 1), with din_valid gaps between bits.
   - Response: q1_q0=11, r1_r0=00, no_idiv=0; shift registers unchanged during gaps.
3. Shift in 0110 then 01 (6 / 1).
   - Response: no_idiv=1, err_count increments to 1.
   - Then 0001 then 00: no_idiv=1, err_count=2.
4. Hold res_ready=0 for 10 cycles in HOLD while driving din_valid=1.
   - Response: din_ready=0, outputs stable, x3_x0 unchanged.
   - Then assert res_ready: next cycle LOAD_X, din_ready=1.
5. Assert reset_=0 asynchronously after 2 dividend bits, and again during HOLD.
   - Response: all outputs 0 immediately, without a clock edge.
   - Then a fresh 0001 then 01 gives q1_q0=01, r1_r0=00.
6. Run 17 infeasible operations (divisor 00).
   - Response: err_count reaches 15 and stays at 15.
